// File: rtl/aes_sub_bytes_seq.sv
// Sequential AES SubBytes / InvSubBytes engine.
// A captured block is substituted LANES bytes per clock using the forward or the inverse
// S-box. The result is held on a valid/ready output until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// BUSY  | substituting one chunk of LANES bytes per cycle, chunk index in cnt
// DONE  | result valid on out_data, held until out_ready
module aes_sub_bytes_seq #(
  parameter int STATE_BYTES = 16,
  parameter int LANES       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_inv,
  input  logic [8*STATE_BYTES-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*STATE_BYTES-1:0] out_data,
  output logic                     busy
);

  localparam int N  = (LANES > 0) ? STATE_BYTES / LANES : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  if (!((STATE_BYTES == 4 || STATE_BYTES == 16) && LANES >= 1 && LANES <= STATE_BYTES &&
        (STATE_BYTES % LANES) == 0)) begin : g_param_err
    $error("aes_sub_bytes_seq: illegal STATE_BYTES=%0d / LANES=%0d", STATE_BYTES, LANES);
  end

  // Entry 0 sits in the most significant byte, so the rows read like the published tables.
  localparam logic [2047:0] FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                     state;
  logic [CW-1:0]              cnt;
  logic [8*STATE_BYTES-1:0]   buffer;
  logic                       mode;

  function automatic logic [7:0] sbox(input logic inv, input logic [7:0] b);
    logic [10:0] idx;
    idx = {8'd255 - b, 3'b000};
    return inv ? INV_TBL[idx +: 8] : FWD_TBL[idx +: 8];
  endfunction

  // Block sequencing: capture, chunked substitution, result hold; flags registered with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      buffer    <= '0;
      mode      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            buffer   <= in_data;
            mode     <= in_inv;
            cnt      <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          for (int l = 0; l < LANES; l++) begin
            buffer[(int'(cnt) * LANES + l) * 8 +: 8] <=
              sbox(mode, buffer[(int'(cnt) * LANES + l) * 8 +: 8]);
          end
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = buffer;

endmodule
